// File: rtl/filtro_pkg.sv
// Shared constants and helpers for the filtro push-button debounce filter.
// The optional one-cycle press pulse is built only when FILTRO_PULSE_EN is defined.
`timescale 1ns/1ps
package filtro_pkg;

  localparam int FILTRO_SYNC_STAGES_DEF   = 2;
  localparam int FILTRO_STABLE_CYCLES_DEF = 4;

  // Width of a counter that must hold values 0..stable_cycles
  function automatic int filtro_cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/filtro_sync_chain.sv
// Generic N-flop synchronizer for a single asynchronous level.
// Clears to 0 on an asynchronous active-high reset; reusable for any async input.
`timescale 1ns/1ps
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the flop chain, oldest sample at the top bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/filtro.sv
// Push-button debounce filter: synchronizer followed by a stability counter.
// boton follows the synchronized input only after it has disagreed for
// STABLE_CYCLES consecutive clocks; any return to the current level restarts the count.
// Optional macro FILTRO_PULSE_EN adds boton_pulse, a one-cycle pulse after each press.
`timescale 1ns/1ps
module filtro
  import filtro_pkg::*;
#(
  parameter int SYNC_STAGES   = FILTRO_SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = FILTRO_STABLE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic boton0,
  output logic boton
`ifdef FILTRO_PULSE_EN
  ,
  output logic boton_pulse
`endif
);

  localparam int               CNT_W   = filtro_cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (Clk),
    .rst (Reset),
    .din (boton0),
    .dout(s)
  );

  // Count consecutive disagreements; commit the new level when the count completes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      boton <= 1'b0;
    end else if (s == boton) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      boton <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef FILTRO_PULSE_EN
  logic boton_prev;

  // Flag the cycle right after boton rises, from a delayed copy of boton
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      boton_prev  <= 1'b0;
      boton_pulse <= 1'b0;
    end else begin
      boton_prev  <= boton;
      boton_pulse <= boton & ~boton_prev;
    end
  end
`endif

endmodule

// File: tb/tb_filtro.sv
// Self-checking bench for filtro: directed scenarios plus randomized bouncing input,
// compared against a history-based reference model of the debounce rule.
`timescale 1ns/1ps
module tb_filtro;
  import filtro_pkg::*;

  localparam int SS = FILTRO_SYNC_STAGES_DEF;
  localparam int SC = FILTRO_STABLE_CYCLES_DEF;

  logic Clk;
  logic Reset;
  logic boton0;
  logic boton;
`ifdef FILTRO_PULSE_EN
  logic boton_pulse;
`endif

  int checks;
  int failures;

  // Reference model: every input value seen at each edge since reset
  bit hist[$];
  int n_edges;
  int last_flip;
  bit m_boton;
  bit m_rose_prev;
  bit m_pulse;

  filtro #(
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .boton0(boton0),
    .boton (boton)
`ifdef FILTRO_PULSE_EN
    ,
    .boton_pulse(boton_pulse)
`endif
  );

  // Free-running 2 ns clock
  initial Clk = 1'b0;
  always #1 Clk = ~Clk;

  // Input level that the filter logic acts on at edge j (synchronizer delay applied)
  function automatic bit seen_at(input int j);
    int idx;
    idx = j - SS;
    if (idx >= 1) return hist[idx-1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_edges     = 0;
    last_flip   = 0;
    m_boton     = 1'b0;
    m_rose_prev = 1'b0;
    m_pulse     = 1'b0;
  endtask

  // boton flips when the last SC seen values since the previous flip all differ from it
  task automatic model_edge(input bit v);
    bit all_diff;
    bit rose;
    n_edges++;
    hist.push_back(v);
    m_pulse = m_rose_prev;
    rose    = 1'b0;
    if (n_edges - last_flip >= SC) begin
      all_diff = 1'b1;
      for (int j = n_edges - SC + 1; j <= n_edges; j++)
        if (seen_at(j) == m_boton) all_diff = 1'b0;
      if (all_diff) begin
        m_boton   = ~m_boton;
        last_flip = n_edges;
        rose      = m_boton;
      end
    end
    m_rose_prev = rose;
  endtask

  task automatic apply_stimulus(input bit v);
    boton0 = v;
    @(posedge Clk);
    model_edge(v);
    @(negedge Clk);
  endtask

  task automatic check_output(input string tag);
    checks++;
    assert (boton === m_boton) else begin
      failures++;
      $error("[TB] FAIL %s boton observed=%0b expected=%0b (edge %0d)", tag, boton, m_boton, n_edges);
    end
`ifdef FILTRO_PULSE_EN
    checks++;
    assert (boton_pulse === m_pulse) else begin
      failures++;
      $error("[TB] FAIL %s_pulse boton_pulse observed=%0b expected=%0b (edge %0d)", tag, boton_pulse, m_pulse, n_edges);
    end
`endif
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold v until boton reaches it; returns edge count (1 = first edge) or -1 on timeout
  task automatic measure_change(input bit v, input int max_edges, input string tag, output int lat);
    lat = -1;
    for (int i = 1; i <= max_edges; i++) begin
      apply_stimulus(v);
      check_output(tag);
      if (lat < 0 && boton === v) lat = i;
    end
  endtask

  task automatic settle(input bit v);
    for (int i = 0; i < SS + SC + 4; i++) begin
      apply_stimulus(v);
      check_output("settle");
    end
  endtask

  initial begin
    int lat;
    int high_cnt;
    int pulse_cnt;
    int run_len;
    bit run_val;

    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    boton0   = 1'b1;
    model_reset();

    // Reset held with the button pressed: output stays low
    $display("[TB] reset hold");
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      check_output("reset_hold");
    end

    // Release and keep pressed: output rises after the full latency
    Reset = 1'b0;
    measure_change(1'b1, 12, "post_reset", lat);
    check_val("reset_latency", lat, SS + SC);

    // Clean 5-cycle press
    $display("[TB] clean pulse");
    settle(1'b0);
    high_cnt  = 0;
    pulse_cnt = 0;
    lat       = -1;
    for (int i = 1; i <= 17; i++) begin
      apply_stimulus(i <= 5);
      check_output("clean_pulse");
      if (boton === 1'b1) high_cnt++;
      if (lat < 0 && boton === 1'b1) lat = i;
`ifdef FILTRO_PULSE_EN
      if (boton_pulse === 1'b1) begin
        pulse_cnt++;
        check_val("pulse_edge", i, SS + SC + 1);
      end
`endif
    end
    check_val("clean_rise_latency", lat, SS + SC);
    check_val("clean_high_cycles", high_cnt, 5);
`ifdef FILTRO_PULSE_EN
    check_val("clean_pulse_count", pulse_cnt, 1);
`endif

    // Glitch shorter than the stability window is rejected
    $display("[TB] glitch");
    settle(1'b0);
    high_cnt  = 0;
    pulse_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(i <= SC - 1);
      check_output("glitch");
      if (boton === 1'b1) high_cnt++;
`ifdef FILTRO_PULSE_EN
      if (boton_pulse === 1'b1) pulse_cnt++;
`endif
    end
    check_val("glitch_high_cycles", high_cnt, 0);
`ifdef FILTRO_PULSE_EN
    check_val("glitch_pulse_count", pulse_cnt, 0);
`endif

    // Bounce 1,0,1,0 then final rise held: latency counts from the final rise
    $display("[TB] bounce");
    settle(1'b0);
    apply_stimulus(1'b1); check_output("bounce");
    apply_stimulus(1'b0); check_output("bounce");
    apply_stimulus(1'b1); check_output("bounce");
    apply_stimulus(1'b0); check_output("bounce");
    measure_change(1'b1, 12, "bounce_hold", lat);
    check_val("bounce_latency", lat, SS + SC);

    // Falling transition mid-count, then asynchronous reset between edges
    $display("[TB] reset mid-count");
    settle(1'b1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0);
      check_output("pre_async_reset");
    end
    #0.3;
    Reset = 1'b1;
    model_reset();
    #0.3;
    check_output("async_reset");
    @(posedge Clk);
    @(negedge Clk);
    check_output("async_reset_hold");
    Reset = 1'b0;
    measure_change(1'b1, 12, "after_reset_rise", lat);
    check_val("after_reset_latency", lat, SS + SC);

    // Falling edge latency with the same rule
    measure_change(1'b0, 12, "fall", lat);
    check_val("fall_latency", lat, SS + SC);

    // Randomized bouncing input against the model
    $display("[TB] random");
    for (int r = 0; r < 120; r++) begin
      run_val = 1'($urandom_range(0, 1));
      run_len = int'($urandom_range(1, SC + 3));
      for (int k = 0; k < run_len; k++) begin
        apply_stimulus(run_val);
        check_output("random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filtro.md
Name: filtro

Overview:
- Push-button debounce filter: takes the raw, asynchronous button level boton0 and produces a clean, glitch-free level boton in the Clk domain.
- Structure: synchronizer chain, then a stability counter; output changes only after the synchronized input has disagreed with it for STABLE_CYCLES consecutive clocks.
- Sits between board-level button pins and control logic.
- One instance per button.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on boton0; legal range 2..4.
- STABLE_CYCLES, 4, consecutive mismatching cycles required before boton updates; legal range 1..65535.
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived localparam, not overridable.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- boton0  input  1  raw button level, asynchronous to Clk, may bounce.
- boton  output  1  debounced button level, registered.

Behaviour:
- Reset asserted (asynchronous, any time):
  - all synchronizer flops = 0, counter = 0, boton = 0.
  - Release of Reset is assumed synchronous to Clk by the system.
- Synchronizer:
  - boton0 shifts through SYNC_STAGES flops each edge.
  - s = last stage output.
  - No other logic reads boton0 directly.
- Each rising edge, out of reset:
  - s == boton: counter <= 0; boton holds.
  - s != boton and counter < STABLE_CYCLES-1: counter <= counter+1; boton holds.
  - s != boton and counter == STABLE_CYCLES-1: boton <= s; counter <= 0.
- Latency: a clean input step applied before edge 1 is reflected on boton after edge SYNC_STAGES+STABLE_CYCLES. Defaults: 6 cycles.
- Glitch rejection:
  - any excursion of s lasting fewer than STABLE_CYCLES cycles leaves boton unchanged.
  - a return of s to boton's value clears the counter, so bounces restart the count.
- Symmetric filtering: the same rule and latency apply to both rising and falling output transitions.
- Counter saturation: the counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- STABLE_CYCLES == 1: boton follows s with one cycle of delay.
- Reset mid-count: counter and boton clear immediately. No pending transition survives reset.
- boton is glitch-free: driven directly from a flop.

Optional Feature:
- Macro: FILTRO_PULSE_EN.
- Defined:
  - adds output boton_pulse (1 bit, registered).
  - boton_pulse is high for exactly one Clk cycle, the cycle after boton transitions 0->1.
  - reset value 0.
  - latency from input step: SYNC_STAGES+STABLE_CYCLES+1 edges.
- Undefined: port and logic absent; behaviour of boton identical.

Decomposition:
- Shared package filtro_pkg holds:
  - default constants FILTRO_SYNC_STAGES_DEF = 2 and FILTRO_STABLE_CYCLES_DEF = 4.
  - localparam helper for counter width.
- One natural sub-module: sync_chain, a parameterized N-flop synchronizer with async active-high reset to 0.
  - Instantiated once inside filtro.
  - Reusable for other asynchronous inputs.

Test Plan:
- Reset: hold Reset=1 with boton0=1 for 10 cycles -> boton=0 throughout, counter=0. Release Reset, keep boton0=1 -> boton=1 exactly 6 edges later.
- Clean pulse: boton0 0->1 for 5 cycles (10 ns at a 2 ns clock period), then 0 -> boton rises 6 edges after the rise, stays high 5 cycles, then falls 6 edges after boton0 falls.
- Glitch rejection: boton0 high for 3 cycles (below STABLE_CYCLES=4) -> boton stays 0, counter returns to 0.
- Bounce: boton0 toggles 1,0,1,0,1 at 1-cycle intervals, then holds 1 -> boton rises only 6 edges after the final rising transition; no intermediate toggles.
- Reset mid-count: boton0=1, assert Reset asynchronously after 4 edges (mid-count) -> boton=0 and counter=0 immediately, without waiting for a clock edge; after release, full 6-cycle latency applies again.
- FILTRO_PULSE_EN defined: a single clean press -> boton_pulse high for exactly 1 cycle at edge 7; no pulse on release; no pulse for a 3-cycle glitch.
